fft_peak_detect: RTL and testbench

- Streaming stage directly downstream of the magnitude-squared stage.
- Consumes one frame of N_BINS magnitude-squared bins, one bin per accepted beat.
- Tracks the largest bin inside a configurable search window.
- Reports the bin index, its magnitude and a noise-floor flag to the pitch/tuner logic once per frame.

---
 rtl/fft_peak_detect.sv | 115 +++++++++++
 tb/tb_fft_peak_detect.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: per-frame windowed peak search over magnitude-squared FFT bins.
// Define PEAK_INTERP_EN to also export the peak's neighbour magnitudes on peak_left/peak_right.
module fft_peak_detect #(
  parameter int bit_width = 16,
  parameter int N_BINS    = 256,
  parameter int MIN_BIN   = 1,
  parameter int MAX_BIN   = 127,
  parameter int THRESH    = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         mag_valid,
  input  logic [2*bit_width-1:0]       mag_in,
  output logic                         busy,
  output logic                         peak_valid,
  output logic                         peak_found,
  output logic [$clog2(N_BINS)-1:0]    peak_bin,
  output logic [2*bit_width-1:0]       peak_mag,
  output logic [2*bit_width-1:0]       peak_left,
  output logic [2*bit_width-1:0]       peak_right
);
  localparam int IW = $clog2(N_BINS);
  localparam int MW = 2 * bit_width;
  localparam logic [IW-1:0] LO   = IW'(MIN_BIN);
  localparam logic [IW-1:0] HI   = IW'(MAX_BIN);
  localparam logic [IW-1:0] LAST = IW'(N_BINS - 1);
  localparam logic [MW-1:0] TH   = MW'(THRESH);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d, idx_q, idx_d, bin_q, bin_d;
  logic [MW-1:0] max_q, max_d, mag_q, mag_d;
  logic          found_q, found_d;
  logic          accept, upd, fin;

  always_comb begin
    accept  = state_q == SCAN && mag_valid && !start;
    upd     = accept && cnt_q >= LO && cnt_q <= HI && mag_in > max_q;
    fin     = accept && cnt_q == LAST;
    state_d = start ? SCAN : fin ? DONE : state_q == SCAN ? SCAN : IDLE;
    cnt_d   = start ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
    max_d   = start ? '0 : upd ? mag_in : max_q;
    idx_d   = start ? '0 : upd ? cnt_q : idx_q;
    bin_d   = fin ? idx_d : bin_q;
    mag_d   = fin ? max_d : mag_q;
    found_d = fin ? max_d >= TH : found_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      max_q   <= '0;
      bin_q   <= '0;
      mag_q   <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
      bin_q   <= bin_d;
      mag_q   <= mag_d;
      found_q <= found_d;
    end
  end

  assign busy       = state_q != IDLE;
  assign peak_valid = state_q == DONE;
  assign peak_found = found_q;
  assign peak_bin   = bin_q;
  assign peak_mag   = mag_q;

`ifdef PEAK_INTERP_EN
  logic [MW-1:0] hist_q, hist_d, left_q, left_d, right_q, right_d, pl_q, pl_d, pr_q, pr_d;
  logic          pend_q, pend_d;

  // A still-pending right candidate at frame end means the peak was the last bin.
  always_comb begin
    hist_d  = accept ? mag_in : hist_q;
    left_d  = start ? '0 : upd ? (cnt_q == '0 ? '0 : hist_q) : left_q;
    pend_d  = start ? 1'b0 : accept ? upd : pend_q;
    right_d = start ? '0 : (accept && pend_q) ? mag_in : right_q;
    pl_d    = fin ? left_d : pl_q;
    pr_d    = fin ? (pend_d ? '0 : right_d) : pr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      pend_q  <= 1'b0;
      pl_q    <= '0;
      pr_q    <= '0;
    end else begin
      hist_q  <= hist_d;
      left_q  <= left_d;
      right_q <= right_d;
      pend_q  <= pend_d;
      pl_q    <= pl_d;
      pr_q    <= pr_d;
    end
  end

  assign peak_left  = pl_q;
  assign peak_right = pr_q;
`else
  assign peak_left  = '0;
  assign peak_right = '0;
`endif
endmodule

// File: tb/tb_fft_peak_detect.sv
// tb_fft_peak_detect: randomized and directed checks of fft_peak_detect against an array-based peak model.
module tb_fft_peak_detect;
  localparam int NB = 16, LO = 1, HI = 14, TH = 100;

  logic        clk, reset, start, mag_valid;
  logic [31:0] mag_in;
  logic        busy, peak_valid, peak_found;
  logic [3:0]  peak_bin;
  logic [31:0] peak_mag, peak_left, peak_right;

  int total = 0, bad = 0, pv_cnt = 0;
  logic [31:0] frame [NB];
  logic [3:0]  exp_bin;
  logic [31:0] exp_mag, exp_left, exp_right;
  logic        exp_found;

  fft_peak_detect #(.bit_width(16), .N_BINS(NB), .MIN_BIN(LO), .MAX_BIN(HI), .THRESH(TH)) dut (
    .clk(clk), .reset(reset), .start(start), .mag_valid(mag_valid), .mag_in(mag_in),
    .busy(busy), .peak_valid(peak_valid), .peak_found(peak_found), .peak_bin(peak_bin),
    .peak_mag(peak_mag), .peak_left(peak_left), .peak_right(peak_right)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(negedge clk) if (peak_valid) pv_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: first strict maximum inside the window, neighbours read straight from the frame.
  function automatic void model();
    exp_mag = 0;
    exp_bin = 0;
    for (int i = LO; i <= HI; i++)
      if (frame[i] > exp_mag) begin
        exp_mag = frame[i];
        exp_bin = 4'(i);
      end
    exp_found = exp_mag >= TH;
    exp_left  = 0;
    exp_right = 0;
`ifdef PEAK_INTERP_EN
    if (exp_mag != 0) begin
      exp_left  = exp_bin == 0 ? 0 : frame[exp_bin - 1];
      exp_right = exp_bin == 4'(NB - 1) ? 0 : frame[exp_bin + 1];
    end
`endif
  endfunction

  function automatic void fill(input logic [31:0] v);
    for (int i = 0; i < NB; i++) frame[i] = v;
  endfunction

  // gap: 0 back-to-back, 1 one idle cycle before each bin, 2 random idle cycles
  task automatic stream(input bit do_start, input bit junk, input int gap, input int nbins);
    if (do_start) begin
      start = 1; mag_valid = junk; mag_in = 32'hFFFF_FFFF;
      tick();
      start = 0; mag_valid = 0;
    end
    for (int i = 0; i < nbins; i++) begin
      repeat (gap == 2 ? $urandom_range(0, 2) : gap) begin
        mag_valid = 0; mag_in = $urandom;
        tick();
      end
      mag_valid = 1; mag_in = frame[i];
      tick();
      mag_valid = 0;
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    total++;
    if ({busy, peak_valid, peak_found, peak_bin, peak_mag, peak_left, peak_right} !== '0) begin
      bad++; $display("FAIL reset_held: got busy=%0b pv=%0b bin=%0d mag=%0d, need all 0", busy, peak_valid, peak_bin, peak_mag);
    end
    reset = 0;
    mag_valid = 1; mag_in = 32'd7777;
    tick(); tick();
    mag_valid = 0;
    total++;
    if ({busy, peak_valid, peak_bin, peak_mag} !== '0) begin
      bad++; $display("FAIL idle_ignores_valid: got busy=%0b pv=%0b bin=%0d mag=%0d, need 0", busy, peak_valid, peak_bin, peak_mag);
    end
  endtask

  task automatic test_single_peak();
    fill(5); frame[5] = 40; frame[6] = 500; frame[7] = 60;
    model();
    stream(1, 0, 0, NB);
    total++;
    if (peak_valid !== 1'b1) begin
      bad++; $display("FAIL single_latency: peak_valid=%0b, need 1", peak_valid);
    end
    total++;
    if ({peak_found, peak_bin, peak_mag} !== {exp_found, exp_bin, exp_mag}) begin
      bad++; $display("FAIL single_result: got f=%0b bin=%0d mag=%0d, need f=%0b bin=%0d mag=%0d", peak_found, peak_bin, peak_mag, exp_found, exp_bin, exp_mag);
    end
    total++;
    if ({peak_left, peak_right} !== {exp_left, exp_right}) begin
      bad++; $display("FAIL single_neigh: got l=%0d r=%0d, need l=%0d r=%0d", peak_left, peak_right, exp_left, exp_right);
    end
    tick();
    total++;
    if ({peak_valid, busy} !== 2'b00) begin
      bad++; $display("FAIL single_pulse_end: got pv=%0b busy=%0b, need 0 0", peak_valid, busy);
    end
  endtask

  task automatic test_window_tie();
    fill(1); frame[0] = 9000; frame[15] = 9000; frame[3] = 300; frame[9] = 300;
    model();
    stream(1, 1, 0, NB);
    total++;
    if ({peak_valid, peak_found, peak_bin, peak_mag} !== {1'b1, exp_found, exp_bin, exp_mag}) begin
      bad++; $display("FAIL window_tie: got pv=%0b f=%0b bin=%0d mag=%0d, need pv=1 f=%0b bin=%0d mag=%0d", peak_valid, peak_found, peak_bin, peak_mag, exp_found, exp_bin, exp_mag);
    end
    total++;
    if ({peak_left, peak_right} !== {exp_left, exp_right}) begin
      bad++; $display("FAIL window_neigh: got l=%0d r=%0d, need l=%0d r=%0d", peak_left, peak_right, exp_left, exp_right);
    end
    tick();
  endtask

  task automatic test_noise();
    fill(50);
    model();
    stream(1, 0, 0, NB);
    total++;
    if ({peak_valid, peak_found, peak_bin, peak_mag} !== {1'b1, 1'b0, 4'd1, 32'd50}) begin
      bad++; $display("FAIL noise_floor: got pv=%0b f=%0b bin=%0d mag=%0d, need pv=1 f=0 bin=1 mag=50", peak_valid, peak_found, peak_bin, peak_mag);
    end
    tick();
  endtask

  task automatic test_stall_abort();
    int p0;
    fill(3); frame[4] = 700;
    model();
    stream(1, 0, 1, NB);
    total++;
    if ({peak_valid, peak_bin, peak_mag} !== {1'b1, exp_bin, exp_mag}) begin
      bad++; $display("FAIL stall_frame: got pv=%0b bin=%0d mag=%0d, need pv=1 bin=%0d mag=%0d", peak_valid, peak_bin, peak_mag, exp_bin, exp_mag);
    end
    tick();
    fill(1); frame[3] = 60000;
    stream(1, 0, 0, 8);
    p0 = pv_cnt;
    start = 1;
    tick();
    start = 0;
    fill(1); frame[10] = 200;
    stream(0, 0, 0, NB);
    model();
    total++;
    if (pv_cnt !== p0 || peak_valid !== 1'b1) begin
      bad++; $display("FAIL abort_no_pulse: got pulses=%0d pv=%0b, need pulses=%0d pv=1", pv_cnt - p0, peak_valid, 0);
    end
    total++;
    if ({peak_bin, peak_mag} !== {exp_bin, exp_mag}) begin
      bad++; $display("FAIL abort_result: got bin=%0d mag=%0d, need bin=%0d mag=%0d", peak_bin, peak_mag, exp_bin, exp_mag);
    end
    tick();
    total++;
    if (pv_cnt !== p0 + 1) begin
      bad++; $display("FAIL abort_pulse_count: got %0d, need 1", pv_cnt - p0);
    end
  endtask

  task automatic test_reset_mid();
    fill(2); frame[3] = 5000;
    stream(1, 0, 0, 7);
    mag_valid = 1; mag_in = 32'd5;
    reset = 1;
    #1;
    total++;
    if ({busy, peak_valid, peak_found, peak_bin, peak_mag, peak_left, peak_right} !== '0) begin
      bad++; $display("FAIL reset_mid: got busy=%0b bin=%0d mag=%0d, need all 0", busy, peak_bin, peak_mag);
    end
    mag_valid = 0;
    tick();
    reset = 0;
    tick();
    fill(10); frame[12] = 999;
    model();
    stream(1, 0, 2, NB);
    total++;
    if ({peak_valid, busy, peak_found, peak_bin, peak_mag} !== {2'b11, exp_found, exp_bin, exp_mag}) begin
      bad++; $display("FAIL post_reset_frame: got pv=%0b f=%0b bin=%0d mag=%0d, need pv=1 f=%0b bin=%0d mag=%0d", peak_valid, peak_found, peak_bin, peak_mag, exp_found, exp_bin, exp_mag);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL busy_fall: busy=%0b, need 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pv_cnt;
    fill(4); frame[2] = 333; frame[1] = 11; frame[3] = 22;
    model();
    stream(1, 0, 0, NB);
    total++;
    if ({peak_valid, peak_bin, peak_mag, peak_left, peak_right} !== {1'b1, exp_bin, exp_mag, exp_left, exp_right}) begin
      bad++; $display("FAIL b2b_first: got pv=%0b bin=%0d mag=%0d, need pv=1 bin=%0d mag=%0d", peak_valid, peak_bin, peak_mag, exp_bin, exp_mag);
    end
    start = 1;
    tick();
    start = 0;
    total++;
    if ({busy, peak_valid} !== 2'b10) begin
      bad++; $display("FAIL b2b_busy: got busy=%0b pv=%0b, need 1 0", busy, peak_valid);
    end
    fill(7); frame[14] = 4321; frame[13] = 15; frame[15] = 16;
    model();
    stream(0, 0, 0, NB);
    total++;
    if ({peak_valid, peak_bin, peak_mag, peak_left, peak_right} !== {1'b1, exp_bin, exp_mag, exp_left, exp_right}) begin
      bad++; $display("FAIL b2b_second: got pv=%0b bin=%0d mag=%0d l=%0d r=%0d, need bin=%0d mag=%0d l=%0d r=%0d", peak_valid, peak_bin, peak_mag, peak_left, peak_right, exp_bin, exp_mag, exp_left, exp_right);
    end
    tick();
    total++;
    if (pv_cnt !== p0 + 2 || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_pulses: got %0d pulses busy=%0b, need 2 pulses busy=0", pv_cnt - p0, busy);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < NB; i++)
        case ($urandom_range(0, 3))
          0: frame[i] = $urandom;
          1: frame[i] = $urandom_range(0, 200);
          2: frame[i] = 300;
          default: frame[i] = 0;
        endcase
      if (f == 0) fill(0);
      if (f == 1) begin fill(1); frame[15] = 77; frame[14] = 77; end
      model();
      stream(1, f[0], 2, NB);
      total++;
      if ({peak_valid, peak_found, peak_bin, peak_mag, peak_left, peak_right} !== {1'b1, exp_found, exp_bin, exp_mag, exp_left, exp_right}) begin
        bad++; $display("FAIL random_%0d: got pv=%0b f=%0b bin=%0d mag=%0d l=%0d r=%0d, need f=%0b bin=%0d mag=%0d l=%0d r=%0d", f, peak_valid, peak_found, peak_bin, peak_mag, peak_left, peak_right, exp_found, exp_bin, exp_mag, exp_left, exp_right);
      end
      if (f[1]) begin
        start = 1;
        tick();
        start = 0;
        stream(0, 0, 0, 0);
        tick();
      end else tick();
    end
  endtask

  initial begin
    reset = 1; start = 0; mag_valid = 0; mag_in = 0;
    test_reset();
    test_single_peak();
    test_window_tie();
    test_noise();
    test_stall_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
